// File: rtl/mod_counter_if.sv
// Bundles the control, limit and status signals of one mod_counter.
// The counter itself uses the slave view. A controller, or a bench, uses the master view.
interface mod_counter_if #(
   parameter int WIDTH  = 8,
   parameter int WRAP_W = 4
);
   logic              clr;
   logic              ld;
   logic [WIDTH-1:0]  ld_val;
   logic [WIDTH-1:0]  lim;
   logic              en;
   logic              dir;
   logic              sat;
   logic [WIDTH-1:0]  cnt_out;
   logic              co;
   logic              at_term;
   logic [WRAP_W-1:0] wraps;

   modport master (
      output clr, ld, ld_val, lim, en, dir, sat,
      input  cnt_out, co, at_term, wraps
   );

   modport slave (
      input  clr, ld, ld_val, lim, en, dir, sat,
      output cnt_out, co, at_term, wraps
   );
endinterface

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with a runtime terminal value, load,
// wrap or saturate mode, a one-cycle terminal pulse and a saturating tally of
// terminal events. Instances cascade: co of one stage drives en of the next.
module mod_counter #(
   parameter int WIDTH  = 8,
   parameter int WRAP_W = 4
) (
   input  logic         clk,
   input  logic         rst,
   mod_counter_if.slave bus
);

   logic [WIDTH-1:0]  cnt_nxt;
   logic [WRAP_W-1:0] wraps_nxt;
   logic              term;

   // The terminal flag depends only on the current count, the limit and the direction.
   assign bus.at_term = bus.dir ? (bus.cnt_out == '0) : (bus.cnt_out >= bus.lim);

   // Next count and terminal-event detection for an enabled cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      cnt_nxt = bus.cnt_out;
      term    = 1'b0;
      if (bus.en) begin
         if (!bus.dir) begin
            if (bus.cnt_out >= bus.lim) begin
               term    = 1'b1;
               cnt_nxt = bus.sat ? bus.cnt_out : '0;
            end else begin
               cnt_nxt = bus.cnt_out + 1'b1;
            end
         end else begin
            if (bus.cnt_out == '0) begin
               term    = 1'b1;
               cnt_nxt = bus.sat ? '0 : bus.lim;
            end else begin
               // A count above lim still steps down by one.
               cnt_nxt = bus.cnt_out - 1'b1;
            end
         end
      end
      // The tally stops at all-ones instead of rolling over.
      wraps_nxt = (term && !(&bus.wraps)) ? bus.wraps + 1'b1 : bus.wraps;
   end

   // State register. Priority is rst, then clr, then ld, then the count step.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values.
      if (rst) begin
         bus.cnt_out <= '0;
         bus.co      <= 1'b0;
         bus.wraps   <= '0;
      end else if (bus.clr) begin
         bus.cnt_out <= '0;
         bus.co      <= 1'b0;
         bus.wraps   <= '0;
      end else if (bus.ld) begin
         bus.cnt_out <= bus.ld_val;
         bus.co      <= 1'b0;
      end else begin
         bus.cnt_out <= cnt_nxt;
         bus.co      <= term;
         bus.wraps   <= wraps_nxt;
      end
   end

endmodule
